param_seq_multiplier: RTL and testbench

PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

---
 rtl/param_seq_mult_pkg.sv | 20 ++
 rtl/mult_sign_unit.sv | 28 ++
 rtl/param_seq_multiplier.sv | 115 +++++++++++
 tb/tb_param_seq_multiplier.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/param_seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// param_seq_mult_pkg : shared FSM states and WIDTH limits  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package param_seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 32;

endpackage

`default_nettype wire

// File: rtl/mult_sign_unit.sv
// ---------------------------------------------------------------------------
// mult_sign_unit : operand magnitudes, result sign and final negation | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_sign_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               neg,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               sign,
  output logic [2*WIDTH-1:0] result
);

  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a  = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign sign   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign result = neg ? -acc : acc;

endmodule

`default_nettype wire

// File: rtl/param_seq_multiplier.sv
// ---------------------------------------------------------------------------
// param_seq_multiplier : sequential shift-add multiplier, WIDTH+1 cycles/op | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_seq_multiplier
  import param_seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 op_sign;
  logic [2*WIDTH-1:0]   fixed_result;

  mult_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .a           (A),
    .b           (B),
    .signed_mode (signed_mode),
    .acc         (acc_q),
    .neg         (sign_q),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .sign        (op_sign),
    .result      (fixed_result)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          sign_d   = op_sign;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Multiplier shifts right so its LSB is always the bit for this step.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        product_d = fixed_result;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_param_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_param_seq_multiplier : directed + random checks for WIDTH=4 and WIDTH=8 | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_param_seq_multiplier;

  logic clk = 1'b0;
  logic reset;

  logic       start4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_checks = 0;
  int n_fail   = 0;

  param_seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
    .A(a4), .B(b4), .product(p4), .busy(busy4), .done(done4)
  );

  param_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .product(p8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: true integer product of the operands as interpreted, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input longint unsigned a, input longint unsigned b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic drive(input int w, input bit st, input bit sm, input int unsigned a, input int unsigned b);
    if (w == 4) begin
      start4 = st; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [63:0] get_prod(input int w);
    return (w == 4) ? 64'(p4) : 64'(p8);
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input string tag, input int w, input bit sm,
                        input int unsigned a_in, input int unsigned b_in, input bit hammer);
    logic [63:0] exp, prev;
    int unsigned a, b;
    int lat, bcnt;
    bit changed;
    a = a_in & ((32'd1 << w) - 1);
    b = b_in & ((32'd1 << w) - 1);
    exp = ref_mul(w, sm, a, b);
    prev = get_prod(w);
    drive(w, 1'b1, sm, a, b);
    lat = -1; bcnt = 0; changed = 1'b0;
    for (int k = 1; k <= w + 6 && lat < 0; k++) begin
      @(negedge clk);
      if (get_done(w)) lat = k - 1;
      else begin
        if (get_busy(w)) bcnt++;
        if (get_prod(w) !== prev) changed = 1'b1;
        if (hammer) drive(w, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        else drive(w, 1'b0, sm, a, b);
      end
    end
    drive(w, 1'b0, sm, a, b);
    check({tag, ".latency"}, 64'(lat), 64'(w + 1));
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'(w + 1));
    check({tag, ".busy_at_done"}, 64'(get_busy(w)), 64'd0);
    check({tag, ".hold"}, 64'(changed), 64'd0);
    check({tag, ".product"}, get_prod(w), exp);
  endtask

  initial begin
    int dcnt;
    reset = 1'b0;
    drive(4, 1'b0, 1'b0, 0, 0);
    drive(8, 1'b0, 1'b0, 0, 0);
    #1;
    check("rst.product4", get_prod(4), 64'd0);
    check("rst.busy4", 64'(busy4), 64'd0);
    check("rst.done4", 64'(done4), 64'd0);
    check("rst.product8", get_prod(8), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("u3x2", 4, 1'b0, 3, 2, 1'b0);
    check("u3x2.fixed", get_prod(4), 64'h06);
    @(negedge clk);
    check("done_single_cycle", 64'(done4), 64'd0);

    run_op("u3x5", 4, 1'b0, 3, 5, 1'b0);
    check("u3x5.fixed", get_prod(4), 64'h0F);
    run_op("b2b15x15", 4, 1'b0, 15, 15, 1'b0);
    check("b2b.fixed", get_prod(4), 64'hE1);

    run_op("s_m3x5", 4, 1'b1, 4'hD, 5, 1'b0);
    check("s_m3x5.fixed", get_prod(4), 64'hF1);
    run_op("s_m8xm8", 4, 1'b1, 4'h8, 4'h8, 1'b0);
    check("s_m8xm8.fixed", get_prod(4), 64'h40);

    run_op("hammer", 4, 1'b0, 6, 7, 1'b1);
    run_op("hammer2", 4, 1'b1, 4'h9, 3, 1'b1);

    run_op("zero", 4, 1'b1, 0, 4'hF, 1'b0);
    run_op("s_m8xm8_again", 4, 1'b1, 4'h8, 4'h8, 1'b0);

    // Abort an operation two cycles into CALC.
    drive(4, 1'b1, 1'b0, 5, 3);
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 5, 3);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort.product", get_prod(4), 64'd0);
    check("abort.busy", 64'(busy4), 64'd0);
    check("abort.done", 64'(done4), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done4) dcnt++;
    end
    check("abort.no_done", 64'(dcnt), 64'd0);
    check("abort.product_held", get_prod(4), 64'd0);
    run_op("post_abort2x7", 4, 1'b0, 2, 7, 1'b0);
    check("post_abort.fixed", get_prod(4), 64'h0E);

    run_op("w8_255x255", 8, 1'b0, 255, 255, 1'b0);
    check("w8_255.fixed", get_prod(8), 64'hFE01);
    run_op("w8_m128xm128", 8, 1'b1, 8'h80, 8'h80, 1'b0);
    check("w8_m128.fixed", get_prod(8), 64'h4000);
    run_op("w8_hammer", 8, 1'b1, 8'hF3, 8'h21, 1'b1);

    for (int i = 0; i < 30; i++) begin
      int w;
      w = ($urandom_range(0, 1) != 0) ? 8 : 4;
      run_op("rand", w, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    check("final.done_low4", 64'(done4), 64'd0);
    check("final.done_low8", 64'(done8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
